// File: rtl/synth_mix_pkg.sv
// Shared types and constants for the voice mixer and the stages around it.
package synth_mix_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCALE,
        SAT
    } mix_state_e;

    localparam sample_t    SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t    SAMPLE_MIN = 16'sh8000;
    localparam logic [15:0] GAIN_UNITY = 16'h8000;

endpackage

// File: rtl/voice_mixer_if.sv
// Voice bus, master gain and mixer status bundled between the voice bank and the mixer.
// The clip_led signal exists only when MIX_CLIP_LED_EN is defined.
interface voice_mixer_if #(
    parameter int NUM_VOICES = 8
);
    import synth_mix_pkg::*;

    sample_t     voice [NUM_VOICES];
    logic [15:0] master_gain;
    sample_t     mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;
`ifdef MIX_CLIP_LED_EN
    logic        clip_led;

    modport master (
        output voice, master_gain,
        input  mix_out, mix_valid, busy, overrun, clip_led
    );

    modport slave (
        input  voice, master_gain,
        output mix_out, mix_valid, busy, overrun, clip_led
    );
`else
    modport master (
        output voice, master_gain,
        input  mix_out, mix_valid, busy, overrun
    );

    modport slave (
        input  voice, master_gain,
        output mix_out, mix_valid, busy, overrun
    );
`endif

endinterface

// File: rtl/lrck_edge_sync.sv
// Brings the asynchronous DAC LR clock into the system clock domain and emits
// a one-cycle pulse on each rising edge. Falling edges produce nothing.
module lrck_edge_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic rise_o
);

    // sync_q[0], sync_q[1] are the synchronizer, sync_q[2] is the edge-detect history
    logic [2:0] sync_q;
    logic       rise_q;

    // Synchronizer chain plus a flopped rising-edge pulse so downstream sees a clean flop output
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
            rise_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: snapshots all voices on each LR-clock frame tick, sums them one
// per cycle, scales by an unsigned Q1.15 master gain and saturates to 16 bits.
// Optional build macro MIX_CLIP_LED_EN adds a clip indicator held for CLIP_HOLD frames.
//
// state | meaning
// IDLE  | waiting for a frame tick; outputs hold the last mix
// ACCUM | adding one snapshotted voice per cycle into the accumulator
// SCALE | registering accumulator x master gain
// SAT   | shifting, saturating and publishing mix_out with a mix_valid pulse
module voice_mixer
    import synth_mix_pkg::*;
#(
    parameter int NUM_VOICES = 8
`ifdef MIX_CLIP_LED_EN
    ,
    parameter int CLIP_HOLD  = 4800
`endif
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          lrck_i,
    voice_mixer_if.slave  mix_if
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = 16 + IDX_W;
    localparam int PROD_W = ACC_W + 17;

    localparam logic signed [PROD_W-1:0] PROD_HI = PROD_W'(SAMPLE_MAX);
    localparam logic signed [PROD_W-1:0] PROD_LO = PROD_W'(SAMPLE_MIN);

    logic tick;

    mix_state_e                state_q, state_d;
    sample_t                   snap_q [NUM_VOICES];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [PROD_W-1:0]  scaled;
    sample_t                   mix_out_q, sat_val;
    logic                      mix_valid_q;
    logic                      overrun_q;
    logic                      snap_en, prod_en, out_en;
    logic                      sat_hi, sat_lo;
    logic signed [16:0]        gain_s;
    sample_t                   cur_voice;

    lrck_edge_sync u_lrck_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (lrck_i),
        .rise_o  (tick)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cur_voice = snap_q[idx_q];

    // Next-state, accumulator/index update and datapath load enables
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        snap_en = 1'b0;
        prod_en = 1'b0;
        out_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    snap_en = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + $signed({{IDX_W{cur_voice[15]}}, cur_voice});
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                prod_en = 1'b1;
                state_d = SAT;
            end
            SAT: begin
                out_en  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gain is unsigned Q1.15; a zero MSB makes it a non-negative signed operand
    assign gain_s = $signed({1'b0, mix_if.master_gain});
    assign prod_d = PROD_W'(acc_q) * PROD_W'(gain_s);

    // Arithmetic shift drops the Q1.15 fraction, rounding toward minus infinity
    assign scaled  = prod_q >>> 15;
    assign sat_hi  = scaled > PROD_HI;
    assign sat_lo  = scaled < PROD_LO;
    assign sat_val = sat_hi ? SAMPLE_MAX :
                     sat_lo ? SAMPLE_MIN : sample_t'(scaled[15:0]);

    // Snapshot bank, accumulator, product, output and sticky overrun registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snap_q      <= '{default: '0};
            acc_q       <= '0;
            idx_q       <= '0;
            prod_q      <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            mix_valid_q <= out_en;
            if (snap_en) begin
                snap_q <= mix_if.voice;
            end
            if (prod_en) begin
                prod_q <= prod_d;
            end
            if (out_en) begin
                mix_out_q <= sat_val;
            end
            if (tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign mix_if.mix_out   = mix_out_q;
    assign mix_if.mix_valid = mix_valid_q;
    assign mix_if.busy      = (state_q != IDLE);
    assign mix_if.overrun   = overrun_q;

`ifdef MIX_CLIP_LED_EN
    localparam int HOLD_W = $clog2(CLIP_HOLD + 1);

    logic [HOLD_W-1:0] clip_cnt_q;

    // Frame-count hold for the clip LED; a fresh clip always reloads the full hold
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clip_cnt_q <= '0;
        end else if (out_en && (sat_hi || sat_lo)) begin
            clip_cnt_q <= HOLD_W'(CLIP_HOLD);
        end else if (tick && (clip_cnt_q != '0)) begin
            clip_cnt_q <= clip_cnt_q - 1'b1;
        end
    end

    assign mix_if.clip_led = (clip_cnt_q != '0);
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: a frame-level model predicts each mix and the
// cycle it must appear; a per-cycle compare checks mix_valid and mix_out.
module tb_voice_mixer;
    import synth_mix_pkg::*;

    localparam int NV  = 8;
    localparam int LAT = NV + 5;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic lrck = 1'b0;

    always #5 clk = ~clk;

    voice_mixer_if #(.NUM_VOICES(NV)) mif ();

    voice_mixer #(.NUM_VOICES(NV)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .lrck_i  (lrck),
        .mix_if  (mif)
    );

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t        q[$];
    int          cyc     = 0;
    int          n_vec   = 0;
    int          n_err   = 0;
    logic [15:0] exp_out = '0;
    logic        exp_ovr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Frame result from first principles: exact sum, exact product, floor by 2^15, clamp
    function automatic logic [15:0] model_mix(input sample_t v [NV], input logic [15:0] g);
        longint sum;
        longint s;
        sum = 0;
        foreach (v[i]) sum += longint'(v[i]);
        s = (sum * longint'(g)) >>> 15;
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    // Per-cycle compare of the output strobe and the held sample
    always @(negedge clk) begin : cmp
        logic exp_v;
        exp_v = 1'b0;
        if (!rst) begin
            exp_v = (q.size() > 0) && (q[0].due == cyc);
            if (exp_v) exp_out = q[0].val;
            check("mix_valid", {15'b0, mif.mix_valid}, {15'b0, exp_v});
            check("mix_out", mif.mix_out, exp_out);
            if (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise lrck; a rise while a frame is still pending must be dropped and flagged
    task automatic start_frame();
        exp_t e;
        if (q.size() > 0) begin
            exp_ovr = 1'b1;
        end else begin
            e.due = cyc + 1 + LAT;
            e.val = model_mix(mif.voice, mif.master_gain);
            q.push_back(e);
        end
        lrck = 1'b1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 4 * LAT && q.size() != 0; i++) step();
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending, want 0", name, q.size());
            q.delete();
        end
        step();
    endtask

    task automatic run_frame(input string name, input sample_t v [NV], input logic [15:0] g,
                             input logic [15:0] want);
        mif.voice       = v;
        mif.master_gain = g;
        step();
        start_frame();
        step();
        step();
        lrck = 1'b0;
        step();
        step();
        step();
        check({name, "_busy"}, {15'b0, mif.busy}, 16'h0001);
        wait_done(name);
        check(name, mif.mix_out, want);
        check({name, "_idle"}, {15'b0, mif.busy}, 16'h0000);
    endtask

    sample_t v1 [NV];
    sample_t v2 [NV];
    sample_t v3 [NV];
    sample_t v4 [NV];
    sample_t v6 [NV];
    sample_t v7 [NV];

    initial begin
        v1 = '{default: 16'sh1000};
        v2 = '{16'sh0100, -16'sh0100, 16'sh0200, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0050};
        v3 = '{default: 16'sh8000};
        v4 = '{16'sh0010, 16'sh0020, 16'sh0030, 16'sh0040, 16'sh0050, 16'sh0060, 16'sh0070, 16'sh0080};
        v6 = '{default: -16'sh0100};
        v7 = '{-16'sh0003, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000, 16'sh0000};

        mif.voice       = '{default: '0};
        mif.master_gain = '0;
        repeat (3) step();
        check("rst_mix_out", mif.mix_out, 16'h0000);
        check("rst_mix_valid", {15'b0, mif.mix_valid}, 16'h0000);
        check("rst_busy", {15'b0, mif.busy}, 16'h0000);
        check("rst_overrun", {15'b0, mif.overrun}, 16'h0000);
        rst = 1'b0;
        step();

        // Positive saturation
        run_frame("pos_sat", v1, GAIN_UNITY, 16'h7FFF);
`ifdef MIX_CLIP_LED_EN
        check("clip_led_set", {15'b0, mif.clip_led}, 16'h0001);
`endif
        // Mixed signs at unity and half gain
        run_frame("mix_unity", v2, GAIN_UNITY, 16'h0250);
        run_frame("mix_half", v2, 16'h4000, 16'h0128);
        // Negative saturation with near-x2 gain
        run_frame("neg_sat", v3, 16'hFFFF, 16'h8000);
        // Floor rounding of a negative fraction: -3 * 0.5 = -1.5 -> -2
        run_frame("neg_floor", v7, 16'h4000, 16'hFFFE);

        // Inputs scrambled every cycle after the snapshot
        mif.voice       = v4;
        mif.master_gain = GAIN_UNITY;
        step();
        start_frame();
        step();
        step();
        lrck = 1'b0;
        step();
        step();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < NV; i++) mif.voice[i] = 16'($urandom);
            step();
        end
        wait_done("snapshot");
        check("snapshot", mif.mix_out, 16'h0240);

        // Second rise five cycles into a frame
        mif.voice       = v2;
        mif.master_gain = GAIN_UNITY;
        step();
        start_frame();
        step();
        step();
        lrck = 1'b0;
        step();
        step();
        step();
        start_frame();
        step();
        step();
        lrck = 1'b0;
        wait_done("overrun_frame");
        check("overrun_frame", mif.mix_out, 16'h0250);
        check("overrun_set", {15'b0, mif.overrun}, {15'b0, exp_ovr});
        run_frame("after_overrun", v2, 16'h4000, 16'h0128);
        check("overrun_sticky", {15'b0, mif.overrun}, 16'h0001);

        // Reset during ACCUM aborts the frame
        mif.voice       = v6;
        mif.master_gain = 16'h6000;
        step();
        start_frame();
        step();
        step();
        lrck = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        q.delete();
        exp_out = '0;
        exp_ovr = 1'b0;
        step();
        check("abort_mix_valid", {15'b0, mif.mix_valid}, 16'h0000);
        check("abort_mix_out", mif.mix_out, 16'h0000);
        check("abort_busy", {15'b0, mif.busy}, 16'h0000);
        check("abort_overrun", {15'b0, mif.overrun}, {15'b0, exp_ovr});
`ifdef MIX_CLIP_LED_EN
        check("clip_led_rst", {15'b0, mif.clip_led}, 16'h0000);
`endif
        rst = 1'b0;
        repeat (20) step();
        run_frame("post_reset", v6, 16'h6000, 16'hFA00);
`ifdef MIX_CLIP_LED_EN
        check("clip_led_clear", {15'b0, mif.clip_led}, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
